// File: rtl/spi_pkg.sv
// spi_pkg: shared definitions for the SPI frame slave.
//   FRAME_BITS_DEFAULT : bits per SPI frame
//   CTRL_W / DATA_W    : split of a received frame into control and data fields
//   spi_state_t        : frame-level FSM states
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 16;
  localparam int CTRL_W = 4;
  localparam int DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } spi_state_t;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchronizer for one asynchronous pin, with registered
// edge strobes.
//   clk   in  : system clock
//   rst_n in  : synchronous active-low reset
//   din   in  : asynchronous pin
//   dout  out : synchronized level
//   rise  out : one-cycle strobe, aligned with dout going high
//   fall  out : one-cycle strobe, aligned with dout going low
// SYNC_STAGES must be at least 2. The edge strobes compare the last two
// stages, so they line up with dout and the pin-to-strobe delay equals the
// chain depth.
module spi_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chainReg;
  logic                   riseReg;
  logic                   fallReg;

  // Reset to 0: a pin already low when reset releases produces no edge, so a
  // chip select held low through reset cannot start a frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chainReg <= '0;
      riseReg  <= 1'b0;
      fallReg  <= 1'b0;
    end else begin
      chainReg <= {chainReg[SYNC_STAGES-2:0], din};
      riseReg  <= chainReg[SYNC_STAGES-2] & ~chainReg[SYNC_STAGES-1];
      fallReg  <= ~chainReg[SYNC_STAGES-2] & chainReg[SYNC_STAGES-1];
    end
  end

  assign dout = chainReg[SYNC_STAGES-1];
  assign rise = riseReg;
  assign fall = fallReg;

endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: SPI mode-0 slave transceiver, oversampled in the clk domain.
//   clk, rst_n          : system clock, synchronous active-low reset
//   sclk, cs_n, mosi    : asynchronous SPI pins from the master
//   miso, miso_oe       : SPI data out and its output enable
//   tx_data             : status word, captured when cs_n falls
//   spi_data            : last good received frame {ctrl, data}
//   readBusy            : high from frame start until one cycle after spi_data updates
//   writeBusy           : high while the transmit shift runs
//   frame_err           : one-cycle pulse when a frame ends with the wrong bit count
module spi_frame_slave
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] spi_data,
  output logic                  readBusy,
  output logic                  writeBusy,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  localparam int PIN_SCLK = 0;
  localparam int PIN_CS   = 1;
  localparam int PIN_MOSI = 2;

  logic [2:0] pinVec;
  logic [2:0] syncVec;
  logic [2:0] riseVec;
  logic [2:0] fallVec;

  assign pinVec = {mosi, cs_n, sclk};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      spi_sync #(
        .SYNC_STAGES(SYNC_STAGES)
      ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (pinVec[gi]),
        .dout (syncVec[gi]),
        .rise (riseVec[gi]),
        .fall (fallVec[gi])
      );
    end
  endgenerate

  logic sclkRise, sclkFall, csRise, csFall, mosiSync;
  assign sclkRise = riseVec[PIN_SCLK];
  assign sclkFall = fallVec[PIN_SCLK];
  assign csRise   = riseVec[PIN_CS];
  assign csFall   = fallVec[PIN_CS];
  assign mosiSync = syncVec[PIN_MOSI];

  // Levels of sclk/cs_n and edges of mosi are not needed.
  logic unusedSync;
  assign unusedSync = ^{syncVec[PIN_SCLK], syncVec[PIN_CS], riseVec[PIN_MOSI], fallVec[PIN_MOSI]};

  spi_state_t            stateReg, stateNext;
  logic [CNT_W-1:0]      cntReg, cntNext;
  logic [FRAME_BITS-1:0] rxReg, rxNext;
  logic [FRAME_BITS-1:0] txReg, txNext;
  logic [FRAME_BITS-1:0] spiDataReg, spiDataNext;
  logic                  misoReg, misoNext;
  logic                  misoOeReg, misoOeNext;
  logic                  readBusyReg, readBusyNext;
  logic                  writeBusyReg, writeBusyNext;
  logic                  frameErrReg, frameErrNext;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg     <= IDLE;
      cntReg       <= '0;
      rxReg        <= '0;
      txReg        <= '0;
      spiDataReg   <= '0;
      misoReg      <= 1'b0;
      misoOeReg    <= 1'b0;
      readBusyReg  <= 1'b0;
      writeBusyReg <= 1'b0;
      frameErrReg  <= 1'b0;
    end else begin
      stateReg     <= stateNext;
      cntReg       <= cntNext;
      rxReg        <= rxNext;
      txReg        <= txNext;
      spiDataReg   <= spiDataNext;
      misoReg      <= misoNext;
      misoOeReg    <= misoOeNext;
      readBusyReg  <= readBusyNext;
      writeBusyReg <= writeBusyNext;
      frameErrReg  <= frameErrNext;
    end
  end

  always_comb begin
    stateNext     = stateReg;
    cntNext       = cntReg;
    rxNext        = rxReg;
    txNext        = txReg;
    spiDataNext   = spiDataReg;
    misoNext      = misoReg;
    misoOeNext    = misoOeReg;
    readBusyNext  = readBusyReg;
    writeBusyNext = writeBusyReg;
    frameErrNext  = 1'b0;

    unique case (stateReg)
      IDLE: begin
        if (csFall) begin
          txNext        = tx_data;
          misoNext      = tx_data[FRAME_BITS-1];
          misoOeNext    = 1'b1;
          readBusyNext  = 1'b1;
          writeBusyNext = 1'b1;
          cntNext       = '0;
          stateNext     = SHIFT;
        end
      end

      SHIFT: begin
        // Chip-select release takes priority over any coincident sclk edge.
        if (csRise) begin
          misoOeNext    = 1'b0;
          writeBusyNext = 1'b0;
          if (cntReg == CNT_FULL) begin
            spiDataNext = {rxReg[FRAME_BITS-1 -: CTRL_W], rxReg[DATA_W-1:0]};
          end else begin
            frameErrNext = 1'b1;
          end
          stateNext = COMMIT;
        end else begin
          if (sclkRise) begin
            rxNext = {rxReg[FRAME_BITS-2:0], mosiSync};
            // Saturating one past a full frame is enough to flag overruns.
            if (cntReg != CNT_MAX) begin
              cntNext = cntReg + 1'b1;
            end
          end
          if (sclkFall) begin
            // Zero fill: once all bits are out, miso settles at 0.
            txNext   = {txReg[FRAME_BITS-2:0], 1'b0};
            misoNext = txReg[FRAME_BITS-2];
          end
        end
      end

      COMMIT: begin
        readBusyNext = 1'b0;
        stateNext    = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  assign miso      = misoReg;
  assign miso_oe   = misoOeReg;
  assign spi_data  = spiDataReg;
  assign readBusy  = readBusyReg;
  assign writeBusy = writeBusyReg;
  assign frame_err = frameErrReg;

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: drives SPI frames as a mode-0 master at clk/8 and
// checks the slave through two monitors fed by expectation queues.
module tb_spi_frame_slave;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        sclk    = 1'b0;
  logic        cs_n    = 1'b1;
  logic        mosi    = 1'b0;
  logic [15:0] tx_data = '0;
  logic        miso;
  logic        miso_oe;
  logic [15:0] spi_data;
  logic        readBusy;
  logic        writeBusy;
  logic        frame_err;

  always #5 clk = ~clk;

  spi_frame_slave dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sclk     (sclk),
    .cs_n     (cs_n),
    .mosi     (mosi),
    .miso     (miso),
    .miso_oe  (miso_oe),
    .tx_data  (tx_data),
    .spi_data (spi_data),
    .readBusy (readBusy),
    .writeBusy(writeBusy),
    .frame_err(frame_err)
  );

  typedef struct {
    logic [15:0] word;
    int          err;
  } frame_exp_t;

  typedef struct {
    logic [15:0] tx;
    int          nbits;
  } miso_exp_t;

  frame_exp_t frameQ[$];
  miso_exp_t  misoQ[$];
  logic       bitsQ[$];

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the word the slave should be holding.
  logic [15:0] modelWord = '0;

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One master transaction. nbits sclk pulses; optional tx_data change after
  // the rising edge of bit changeAt; optional reset after resetAt pulses.
  task automatic doFrame(input logic [15:0] tx, input logic [15:0] word, input int nbits,
                         input int gap, input int changeAt, input logic [15:0] newTx,
                         input int resetAt);
    bit aborted;
    int seen;
    int b;
    aborted = 1'b0;
    seen = (resetAt >= 0 && resetAt < nbits) ? resetAt : nbits;
    misoQ.push_back('{tx, seen});
    @(negedge clk);
    tx_data = tx;
    cs_n    = 1'b0;
    waitClk(5);
    for (int i = 0; i < nbits; i++) begin
      b = 15 - i;
      if (i < 16) mosi = word[b];
      else mosi = 1'($urandom_range(1));
      waitClk(4);
      sclk = 1'b1;
      if (i == changeAt) tx_data = newTx;
      waitClk(4);
      sclk = 1'b0;
      if (i + 1 == resetAt) begin
        rst_n = 1'b0;
        waitClk(3);
        rst_n = 1'b1;
        aborted = 1'b1;
        break;
      end
    end
    waitClk(4);
    cs_n = 1'b1;
    if (aborted) begin
      modelWord = '0;
    end else if (nbits == 16) begin
      modelWord = word;
      frameQ.push_back('{modelWord, 0});
    end else begin
      frameQ.push_back('{modelWord, 1});
    end
    waitClk(gap);
  endtask

  // Frame monitor: samples 1 time unit after each rising clk edge.
  initial begin
    bit          prevBusy;
    logic [15:0] prevSpi;
    int          errCount;
    int          errBase;
    frame_exp_t  fe;
    prevBusy = 1'b0;
    prevSpi  = '0;
    errCount = 0;
    errBase  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        compared++;
        if ({spi_data, miso, miso_oe, readBusy, writeBusy, frame_err} !== 21'd0) begin
          mismatched++;
          $display("FAIL reset_state: got spi_data=%h miso=%b miso_oe=%b readBusy=%b writeBusy=%b frame_err=%b, required all 0",
                   spi_data, miso, miso_oe, readBusy, writeBusy, frame_err);
        end
        prevBusy = 1'b0;
        prevSpi  = spi_data;
        errBase  = errCount;
      end else begin
        if (frame_err === 1'b1) errCount++;
        if (!prevBusy && readBusy === 1'b1) begin
          compared++;
          if (writeBusy !== 1'b1 || miso_oe !== 1'b1) begin
            mismatched++;
            $display("FAIL frame_start: got writeBusy=%b miso_oe=%b, required 1 1", writeBusy, miso_oe);
          end
        end
        if (prevBusy && readBusy === 1'b0) begin
          compared++;
          if (frameQ.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_commit: got readBusy fall with spi_data=%h, required none", prevSpi);
          end else begin
            fe = frameQ.pop_front();
            if (prevSpi !== fe.word || spi_data !== fe.word) begin
              mismatched++;
              $display("FAIL spi_data: got %h before fall / %h at fall, required %h", prevSpi, spi_data, fe.word);
            end
            compared++;
            if (errCount - errBase != fe.err) begin
              mismatched++;
              $display("FAIL frame_err: got %0d pulse cycles, required %0d", errCount - errBase, fe.err);
            end
            compared++;
            if (writeBusy !== 1'b0 || miso_oe !== 1'b0) begin
              mismatched++;
              $display("FAIL frame_end: got writeBusy=%b miso_oe=%b, required 0 0", writeBusy, miso_oe);
            end
            $display("commit: spi_data=%h expected err=%0d", spi_data, fe.err);
          end
          errBase = errCount;
        end
        prevBusy = (readBusy === 1'b1);
        prevSpi  = spi_data;
      end
    end
  end

  // MISO capture: master samples on each sclk rise while selected.
  initial begin
    forever begin
      @(posedge sclk);
      if (cs_n === 1'b0) bitsQ.push_back(miso);
    end
  end

  // MISO check at each chip-select release.
  initial begin
    miso_exp_t   me;
    logic [31:0] expV;
    logic [31:0] gotV;
    int          nGot;
    int          b;
    forever begin
      @(posedge cs_n);
      if (misoQ.size() > 0) begin
        me   = misoQ.pop_front();
        expV = '0;
        gotV = '0;
        for (int i = 0; i < me.nbits; i++) begin
          b = 15 - i;
          if (i < 16) expV = {expV[30:0], me.tx[b]};
          else expV = {expV[30:0], 1'b0};
        end
        nGot = bitsQ.size();
        while (bitsQ.size() > 0) gotV = {gotV[30:0], bitsQ.pop_front()};
        compared++;
        if (nGot != me.nbits || gotV !== expV) begin
          mismatched++;
          $display("FAIL miso_bits: got %0d bits %h, required %0d bits %h", nGot, gotV, me.nbits, expV);
        end else begin
          $display("miso frame: %0d bits %h", nGot, gotV);
        end
      end else begin
        bitsQ.delete();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    waitClk(5);
    rst_n = 1'b1;
    waitClk(8);

    doFrame(16'hA5C3, 16'h2ABC, 16, 10, -1, 16'h0, -1);
    doFrame(16'($urandom), 16'hFFFF, 10, 10, -1, 16'h0, -1);
    doFrame(16'($urandom), 16'($urandom), 17, 10, -1, 16'h0, -1);
    doFrame(16'h1234, 16'($urandom), 16, 10, 3, 16'hFFFF, -1);
    doFrame(16'($urandom), 16'($urandom), 16, 10, -1, 16'h0, 8);
    doFrame(16'($urandom), 16'h6001, 16, 10, -1, 16'h0, -1);
    doFrame(16'($urandom), 16'h2123, 16, 5, -1, 16'h0, -1);
    doFrame(16'($urandom), 16'h3045, 16, 5, -1, 16'h0, -1);

    for (int k = 0; k < 30; k++) begin
      nb = ($urandom_range(3) == 0) ? int'($urandom_range(18)) : 16;
      doFrame(16'($urandom), 16'($urandom), nb, int'($urandom_range(10, 5)), -1, 16'h0, -1);
    end

    waitClk(20);
    compared++;
    if (frameQ.size() != 0 || misoQ.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_expectations: got %0d frames / %0d miso pending, required 0 / 0",
               frameQ.size(), misoQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
